// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier with valid/ready handshake.
// Define WALLACE_SIGNED_EN to add per-transaction two's-complement mode (Baugh-Wooley).
module wallace_mult_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_signed
);

  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = 8;

`ifdef WALLACE_SIGNED_EN
  localparam int NROWS = WIDTH + 1;
  logic sg1, sg2;
`else
  localparam int NROWS = WIDTH;
  logic unused_signed;
  assign unused_signed = in_signed;
  assign out_signed    = 1'b0;
`endif

  // Row count left after lv levels of 3:2 compression; 8 levels cover WIDTH up to 32.
  function automatic int rows_after(input int r0, input int lv);
    int r;
    r = r0;
    for (int k = 0; k < lv; k++)
      if (r > 2) r = r - r / 3;
    return r;
  endfunction

  logic             v1, v2;
  logic [WIDTH-1:0] a1, b1;
  logic [PW-1:0]    sum2, car2;
  logic             ld1, ld2, ld3;
  logic [PW-1:0]    pp   [NROWS];
  logic [PW-1:0]    tree [LEVELS+1][NROWS];

  assign ld3      = !out_valid || out_ready;
  assign ld2      = !v2 || ld3;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1 && !rst;

  // Signed mode inverts the cross sign terms and adds 2^WIDTH + 2^(2*WIDTH-1).
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
`ifdef WALLACE_SIGNED_EN
        pp[i][i+j] = (a1[j] & b1[i]) ^ (sg1 & ((i == WIDTH-1) != (j == WIDTH-1)));
`else
        pp[i][i+j] = a1[j] & b1[i];
`endif
      end
    end
`ifdef WALLACE_SIGNED_EN
    pp[WIDTH] = sg1 ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
`endif
  end

  for (genvar i = 0; i < NROWS; i++) begin : g_leaf
    assign tree[0][i] = pp[i];
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int N = rows_after(NROWS, l);
    localparam int G = (N > 2) ? N / 3 : 0;
    localparam int M = N - G;
    for (genvar i = 0; i < NROWS; i++) begin : g_slot
      if (i < G) begin : g_csa
        assign tree[l+1][2*i]   = tree[l][3*i] ^ tree[l][3*i+1] ^ tree[l][3*i+2];
        assign tree[l+1][2*i+1] = ((tree[l][3*i]   & tree[l][3*i+1]) |
                                   (tree[l][3*i]   & tree[l][3*i+2]) |
                                   (tree[l][3*i+1] & tree[l][3*i+2])) << 1;
      end
      if (i >= 3*G && i < N) begin : g_pass
        assign tree[l+1][i-G] = tree[l][i];
      end
      if (i >= M) begin : g_zero
        assign tree[l+1][i] = '0;
      end
    end
  end

  // Each stage loads whenever it is empty or its successor is loading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid   <= 1'b0;
      a1          <= '0;
      b1          <= '0;
      sum2        <= '0;
      car2        <= '0;
      out_product <= '0;
`ifdef WALLACE_SIGNED_EN
      sg1         <= 1'b0;
      sg2         <= 1'b0;
      out_signed  <= 1'b0;
`endif
    end else begin
      if (ld1) begin
        v1 <= in_valid;
        if (in_valid) begin
          a1 <= in_a;
          b1 <= in_b;
`ifdef WALLACE_SIGNED_EN
          sg1 <= in_signed;
`endif
        end
      end
      if (ld2) begin
        v2 <= v1;
        if (v1) begin
          sum2 <= tree[LEVELS][0];
          car2 <= tree[LEVELS][1];
`ifdef WALLACE_SIGNED_EN
          sg2 <= sg1;
`endif
        end
      end
      if (ld3) begin
        out_valid <= v2;
        if (v2) begin
          out_product <= sum2 + car2;
`ifdef WALLACE_SIGNED_EN
          out_signed <= sg2;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Self-checking bench for wallace_mult_pipe: directed 8-bit cases plus a random 16-bit run.
// Products are checked against a plain-arithmetic model; honours WALLACE_SIGNED_EN.
module tb_wallace_mult_pipe;

`ifdef WALLACE_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, out_signed8;
  logic [7:0]  in_a8, in_b8;
  logic [15:0] out_product8;
  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, out_signed16;
  logic [15:0] in_a16, in_b16;
  logic [31:0] out_product16;

  int checks = 0;
  int errors = 0;
  int acc8 = 0, out8 = 0, acc16 = 0, out16 = 0;
  logic [31:0] exp8_q[$], exp16_q[$];
  bit          sg8_q[$], sg16_q[$];
  bit          hold8 = 1'b0, hold16 = 1'b0;
  logic [15:0] held8;
  logic [31:0] held16;
  logic        held_sg8, held_sg16;

  wallace_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_a(in_a8), .in_b(in_b8), .in_signed(in_signed8),
    .out_valid(out_valid8), .out_ready(out_ready8), .out_product(out_product8), .out_signed(out_signed8)
  );

  wallace_mult_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16), .in_signed(in_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_product(out_product16), .out_signed(out_signed16)
  );

  function automatic bit eff_sg(input bit s);
    return s & SIGNED_EN;
  endfunction

  // Reference: extend each operand to an integer value, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                          input bit sg, input int w);
    longint ea, eb, p;
    ea = longint'(a);
    eb = longint'(b);
    if (sg && a[w-1]) ea = ea - (longint'(1) << w);
    if (sg && b[w-1]) eb = eb - (longint'(1) << w);
    p = ea * eb;
    return 32'(p & ((longint'(1) << (2*w)) - 1));
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input bit s);
    in_valid8  = 1'b1;
    in_a8      = a;
    in_b8      = b;
    in_signed8 = s;
  endtask

  // One isolated transaction: checks latency, product and mode bit.
  task automatic run_single(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input bit s, input logic [15:0] exp);
    int lat;
    apply_stimulus(a, b, s);
    check_output({tag, "_rdy"}, 32'(in_ready8), 32'd1);
    @(posedge clk); #1;
    lat = 1;
    in_valid8 = 1'b0;
    while (!out_valid8 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output({tag, "_lat"}, lat, 32'd3);
    check_output({tag, "_prod"}, 32'(out_product8), 32'(exp));
    check_output({tag, "_sgn"}, 32'(out_signed8), 32'(eff_sg(s)));
    @(posedge clk); #1;
  endtask

  // Scoreboard: records accepted operands and checks every delivered product and stall hold.
  always @(negedge clk) begin
    if (rst) begin
      hold8  = 1'b0;
      hold16 = 1'b0;
    end else begin
      if (in_valid8 && in_ready8) begin
        exp8_q.push_back(ref_mul({8'h00, in_a8}, {8'h00, in_b8}, eff_sg(in_signed8), 8));
        sg8_q.push_back(eff_sg(in_signed8));
        acc8++;
      end
      if (hold8) begin
        check_output("hold8_valid", 32'(out_valid8), 32'd1);
        check_output("hold8_prod", 32'(out_product8), 32'(held8));
        check_output("hold8_sgn", 32'(out_signed8), 32'(held_sg8));
      end
      if (out_valid8 && out_ready8) begin
        check_output("stale8", 32'(exp8_q.size() != 0), 32'd1);
        if (exp8_q.size() != 0) begin
          check_output("prod8", 32'(out_product8), exp8_q.pop_front());
          check_output("sgn8", 32'(out_signed8), 32'(sg8_q.pop_front()));
        end
        out8++;
      end
      hold8    = out_valid8 && !out_ready8;
      held8    = out_product8;
      held_sg8 = out_signed8;

      if (in_valid16 && in_ready16) begin
        exp16_q.push_back(ref_mul(in_a16, in_b16, eff_sg(in_signed16), 16));
        sg16_q.push_back(eff_sg(in_signed16));
        acc16++;
      end
      if (hold16) begin
        check_output("hold16_valid", 32'(out_valid16), 32'd1);
        check_output("hold16_prod", out_product16, held16);
        check_output("hold16_sgn", 32'(out_signed16), 32'(held_sg16));
      end
      if (out_valid16 && out_ready16) begin
        check_output("stale16", 32'(exp16_q.size() != 0), 32'd1);
        if (exp16_q.size() != 0) begin
          check_output("prod16", out_product16, exp16_q.pop_front());
          check_output("sgn16", 32'(out_signed16), 32'(sg16_q.pop_front()));
        end
        out16++;
      end
      hold16    = out_valid16 && !out_ready16;
      held16    = out_product16;
      held_sg16 = out_signed16;
    end
  end

  initial begin
    int base, base_out;
    bit took;
    logic [15:0] a16, b16;

    rst = 1'b0;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_signed8 = 1'b0; out_ready8 = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0; out_ready16 = 1'b1;
    #1 rst = 1'b1;
    #1;
    check_output("rst_valid", 32'(out_valid8), 32'd0);
    check_output("rst_prod", 32'(out_product8), 32'd0);
    check_output("rst_sgn", 32'(out_signed8), 32'd0);
    check_output("rst_ready", 32'(in_ready8), 32'd0);
    check_output("rst_valid16", 32'(out_valid16), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("rdy_after_rst", 32'(in_ready8), 32'd1);
    check_output("rdy_after_rst16", 32'(in_ready16), 32'd1);

    $display("[TB] directed single transactions");
    run_single("u_aa55", 8'hAA, 8'h55, 1'b0, 16'h3872);
    run_single("u_ffff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run_single("u_ff01", 8'hFF, 8'h01, 1'b0, 16'h00FF);
    run_single("s_ffff", 8'hFF, 8'hFF, 1'b1, SIGNED_EN ? 16'h0001 : 16'hFE01);
    run_single("s_807f", 8'h80, 8'h7F, 1'b1, SIGNED_EN ? 16'hC080 : 16'h3F80);
    run_single("s_8080", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_single("s_03fd", 8'h03, 8'hFD, 1'b1, SIGNED_EN ? 16'hFFF7 : 16'h02F7);

    $display("[TB] back-to-back stream");
    base = out8;
    for (int k = 0; k < 20; k++) begin
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));
      check_output("stream_rdy", 32'(in_ready8), 32'd1);
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_output("stream_count", out8 - base, 32'd20);
    check_output("stream_idle", 32'(out_valid8), 32'd0);

    $display("[TB] backpressure");
    out_ready8 = 1'b0;
    base = acc8;
    base_out = out8;
    took = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (took) apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));
      #1 took = in_ready8;
      @(posedge clk); #1;
    end
    check_output("bp_accepted", acc8 - base, 32'd3);
    check_output("bp_ready_low", 32'(in_ready8), 32'd0);
    check_output("bp_valid", 32'(out_valid8), 32'd1);
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    #1;
    check_output("bp_release_rdy", 32'(in_ready8), 32'd1);
    for (int k = 0; k < 20 && exp8_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check_output("bp_drain_empty", exp8_q.size(), 32'd0);
    check_output("bp_drain_count", out8 - base_out, 32'd3);
    check_output("bp_drain_idle", 32'(out_valid8), 32'd0);

    $display("[TB] reset with transactions in flight");
    out_ready8 = 1'b0;
    base = acc8;
    repeat (3) begin
      apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));
      @(posedge clk); #1;
    end
    in_valid8 = 1'b0;
    check_output("flight_accepted", acc8 - base, 32'd3);
    check_output("flight_valid", 32'(out_valid8), 32'd1);
    rst = 1'b1;
    #1;
    check_output("midrst_valid", 32'(out_valid8), 32'd0);
    check_output("midrst_ready", 32'(in_ready8), 32'd0);
    check_output("midrst_prod", 32'(out_product8), 32'd0);
    exp8_q.delete();
    sg8_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready8 = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check_output("post_rst_idle", 32'(out_valid8), 32'd0);
    end
    run_single("rst_new", 8'h03, 8'h03, 1'b0, 16'h0009);

    $display("[TB] random 16-bit run");
    for (int cyc = 0; cyc < 20000 && !(acc16 >= 1000 && exp16_q.size() == 0); cyc++) begin
      case ($urandom_range(0, 7))
        0:       a16 = 16'h8000;
        1:       a16 = 16'hFFFF;
        2:       a16 = 16'h7FFF;
        default: a16 = 16'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       b16 = 16'h8000;
        1:       b16 = 16'hFFFF;
        2:       b16 = 16'h0001;
        default: b16 = 16'($urandom);
      endcase
      in_valid16  = (acc16 < 1000) && ($urandom_range(0, 3) != 0);
      in_a16      = a16;
      in_b16      = b16;
      in_signed16 = 1'($urandom);
      out_ready16 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    in_valid16 = 1'b0;
    out_ready16 = 1'b1;
    check_output("rand16_accepted", acc16, 32'd1000);
    check_output("rand16_delivered", out16, 32'd1000);
    check_output("rand16_empty", exp16_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
